// File: rtl/i2s_play_ctrl_pkg.sv
// Shared state type and default timing constants for the I2S play sequencer.
package i2s_play_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_CFG,
    PC_RUN,
    PC_DRAIN
  } play_ctrl_state_t;

  localparam int unsigned I2S_TICK_DIV0       = 1536;
  localparam int unsigned I2S_TICK_DIV1       = 768;
  localparam int unsigned I2S_TICK_DIV2       = 384;
  localparam int unsigned I2S_TICK_DIV3       = 384;
  localparam int unsigned I2S_MIN_PLAY_CYCLES = 384;
  localparam int unsigned I2S_DRAIN_MAX       = 1024;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/i2s_play_ctrl_if.sv
// Host command / i2s control bundle for i2s_play_ctrl.
// underrun_out exists only when I2S_PLAY_CTRL_UNDERRUN_EN is defined.
interface i2s_play_ctrl_if;
  logic        start_in;
  logic        stop_in;
  logic        cfg_wr_in;
  logic [31:0] cfg_data_in;
  logic        req_in;
  logic        ws_in;
  logic        play_out;
  logic        cfg_out;
  logic [31:0] cfg_reg_out;
  logic        tick_out;
  logic        busy_out;
  logic        done_out;
`ifdef I2S_PLAY_CTRL_UNDERRUN_EN
  logic        underrun_out;
`endif

  modport master (
`ifdef I2S_PLAY_CTRL_UNDERRUN_EN
    input  underrun_out,
`endif
    output start_in, stop_in, cfg_wr_in, cfg_data_in, req_in, ws_in,
    input  play_out, cfg_out, cfg_reg_out, tick_out, busy_out, done_out
  );

  modport slave (
`ifdef I2S_PLAY_CTRL_UNDERRUN_EN
    output underrun_out,
`endif
    input  start_in, stop_in, cfg_wr_in, cfg_data_in, req_in, ws_in,
    output play_out, cfg_out, cfg_reg_out, tick_out, busy_out, done_out
  );
endinterface

// File: rtl/i2s_play_ctrl_tick_gen.sv
// Sample tick divider: period selected by mode, registered one-cycle tick when the
// count sits at zero while enabled.
module i2s_tick_gen
  import i2s_play_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV0 = I2S_TICK_DIV0,
  parameter int unsigned TICK_DIV1 = I2S_TICK_DIV1,
  parameter int unsigned TICK_DIV2 = I2S_TICK_DIV2,
  parameter int unsigned TICK_DIV3 = I2S_TICK_DIV3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_mode,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic       o_tick
);
  localparam int unsigned MaxDiv = max4(TICK_DIV0, TICK_DIV1, TICK_DIV2, TICK_DIV3);
  localparam int unsigned CntW   = $clog2(MaxDiv);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_last;
  logic            r_tick;

  always_comb begin
    w_last = '0;
    unique case (i_mode)
      2'd0: w_last = CntW'(TICK_DIV0 - 1);
      2'd1: w_last = CntW'(TICK_DIV1 - 1);
      2'd2: w_last = CntW'(TICK_DIV2 - 1);
      2'd3: w_last = CntW'(TICK_DIV3 - 1);
      default: w_last = '0;
    endcase
  end

  // Count zero right after a clear, so the first tick lands one enabled cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= i_enable && (r_cnt == '0);
      if (i_enable) begin
        r_cnt <= (r_cnt >= w_last) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/i2s_play_ctrl.sv
// I2S play sequencer: turns host start/stop/config commands into legal play/cfg/tick
// sequences. Optional underrun flag enabled by defining I2S_PLAY_CTRL_UNDERRUN_EN.
module i2s_play_ctrl
  import i2s_play_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV0       = I2S_TICK_DIV0,
  parameter int unsigned TICK_DIV1       = I2S_TICK_DIV1,
  parameter int unsigned TICK_DIV2       = I2S_TICK_DIV2,
  parameter int unsigned TICK_DIV3       = I2S_TICK_DIV3,
  parameter int unsigned MIN_PLAY_CYCLES = I2S_MIN_PLAY_CYCLES,
  parameter int unsigned DRAIN_MAX       = I2S_DRAIN_MAX
) (
  input logic            clk,
  input logic            rst_n,
  i2s_play_ctrl_if.slave bus
);
  localparam int unsigned GuardW = $clog2(MIN_PLAY_CYCLES + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_MAX + 1);

  play_ctrl_state_t  r_state, w_state_d;
  logic [GuardW-1:0] r_guard;
  logic [DrainW-1:0] r_drain;
  logic              r_stop_pend, w_stop_pend_d;
  logic              r_ws, r_play, r_cfg, r_busy, r_done;
  logic [31:0]       r_cfg_reg;
  logic [1:0]        r_mode;
  logic              w_guard_ok, w_ws_fall, w_drain_end;
  logic              w_start_acc, w_cfg_acc, w_drain_exit;
  logic              w_tick_en, w_tick;

  assign w_guard_ok  = (r_guard == GuardW'(MIN_PLAY_CYCLES));
  assign w_ws_fall   = r_ws & ~bus.ws_in;
  assign w_drain_end = w_ws_fall | (r_drain == DrainW'(DRAIN_MAX - 1));

  always_comb begin
    w_state_d     = r_state;
    w_stop_pend_d = r_stop_pend;
    w_start_acc   = 1'b0;
    w_cfg_acc     = 1'b0;
    w_drain_exit  = 1'b0;
    unique case (r_state)
      PC_IDLE: begin
        if (bus.cfg_wr_in) begin
          w_state_d = PC_CFG;
          w_cfg_acc = 1'b1;
        end else if (bus.start_in && !bus.stop_in && w_guard_ok) begin
          w_state_d   = PC_RUN;
          w_start_acc = 1'b1;
        end
      end
      PC_CFG: w_state_d = PC_IDLE;
      PC_RUN: begin
        if (bus.stop_in) w_stop_pend_d = 1'b1;
        if ((bus.stop_in || r_stop_pend) && w_guard_ok) begin
          w_state_d     = PC_DRAIN;
          w_stop_pend_d = 1'b0;
        end
      end
      PC_DRAIN: begin
        if (w_drain_end) begin
          w_state_d    = PC_IDLE;
          w_drain_exit = 1'b1;
        end
      end
      default: w_state_d = PC_IDLE;
    endcase
  end

  // Guard counts cycles since play last changed, the changing cycle included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PC_IDLE;
      r_stop_pend <= 1'b0;
      r_guard     <= GuardW'(MIN_PLAY_CYCLES);
      r_drain     <= '0;
      r_ws        <= 1'b0;
      r_play      <= 1'b0;
      r_cfg       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_reg   <= '0;
      r_mode      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_stop_pend <= w_stop_pend_d;
      r_ws        <= bus.ws_in;
      r_play      <= (w_state_d == PC_RUN) || (w_state_d == PC_DRAIN);
      r_cfg       <= w_cfg_acc;
      r_busy      <= (w_state_d != PC_IDLE);
      r_done      <= w_drain_exit;
      if (w_start_acc || w_drain_exit) begin
        r_guard <= GuardW'(1);
      end else if (!w_guard_ok) begin
        r_guard <= r_guard + 1'b1;
      end
      r_drain <= (r_state == PC_DRAIN) ? r_drain + 1'b1 : '0;
      if (w_cfg_acc) begin
        r_cfg_reg <= bus.cfg_data_in;
        r_mode    <= bus.cfg_data_in[1:0];
      end
    end
  end

  // No tick on the cycle RUN is left, so ticks stop the moment DRAIN begins.
  assign w_tick_en = (r_state == PC_RUN) && (w_state_d == PC_RUN);

  i2s_tick_gen #(
    .TICK_DIV0(TICK_DIV0),
    .TICK_DIV1(TICK_DIV1),
    .TICK_DIV2(TICK_DIV2),
    .TICK_DIV3(TICK_DIV3)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mode  (r_mode),
    .i_clear (w_start_acc),
    .i_enable(w_tick_en),
    .o_tick  (w_tick)
  );

  assign bus.play_out    = r_play;
  assign bus.cfg_out     = r_cfg;
  assign bus.cfg_reg_out = r_cfg_reg;
  assign bus.tick_out    = w_tick;
  assign bus.busy_out    = r_busy;
  assign bus.done_out    = r_done;

`ifdef I2S_PLAY_CTRL_UNDERRUN_EN
  logic r_req_seen, r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_seen <= 1'b0;
      r_underrun <= 1'b0;
    end else if (w_start_acc) begin
      r_req_seen <= 1'b0;
      r_underrun <= 1'b0;
    end else if (r_state == PC_RUN) begin
      if (bus.req_in && r_req_seen && !w_tick) r_underrun <= 1'b1;
      if (w_tick) begin
        r_req_seen <= bus.req_in;
      end else if (bus.req_in) begin
        r_req_seen <= 1'b1;
      end
    end
  end

  assign bus.underrun_out = r_underrun;
`endif

endmodule

// File: doc/i2s_play_ctrl.md
Name: i2s_play_ctrl

Overview:
- Sequencer for the I2S transmitter datapath. Drives its play, cfg, cfg_reg and tick inputs, and watches its req and ws outputs.
- Turns host start/stop/config commands into legal i2s control sequences:
  - one-cycle cfg and tick pulses
  - play held stable at least MIN_PLAY_CYCLES after every change
  - ticks only while playing
  - stop deferred to a frame boundary
- Sits between the control unit and the i2s unit inside audioport.

Parameters:
- TICK_DIV0, 1536, tick period in clk cycles for cfg mode 0
- TICK_DIV1, 768, tick period for mode 1
- TICK_DIV2, 384, tick period for mode 2
- TICK_DIV3, 384, tick period for mode 3
- MIN_PLAY_CYCLES, 384, minimum cycles play_out stays stable after a change
- DRAIN_MAX, 1024, stop timeout in cycles if no frame boundary seen

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_in  in  1  one-cycle start command
- stop_in  in  1  one-cycle stop command
- cfg_wr_in  in  1  one-cycle config write
- cfg_data_in  in  32  config word; bits [1:0] select mode
- req_in  in  1  data request pulse from i2s unit
- ws_in  in  1  word select from i2s unit
- play_out  out  1  play enable to i2s unit
- cfg_out  out  1  one-cycle config strobe to i2s unit
- cfg_reg_out  out  32  config word to i2s unit
- tick_out  out  1  one-cycle sample tick to i2s unit
- busy_out  out  1  high in any state other than IDLE
- done_out  out  1  one-cycle pulse when a stop completes

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, counters 0, guard counter = MIN_PLAY_CYCLES (already satisfied).
- States:
  - IDLE: play_out=0.
  - CFG: single cycle; cfg_out=1.
  - RUN: play_out=1.
  - DRAIN: play_out=1, no ticks.
- Registered outputs: all outputs are registered, so effect appears the cycle after the triggering input.
- IDLE + cfg_wr_in:
  - cfg_reg_out <= cfg_data_in, mode_r <= cfg_data_in[1:0].
  - Go to CFG; cfg_out high exactly one cycle, then back to IDLE.
- Config in other states: cfg_wr_in in CFG, RUN or DRAIN is ignored. cfg_reg_out and cfg_out are unchanged.
- IDLE + start_in:
  - Requires guard elapsed and no cfg_wr_in the same cycle. If cfg_wr_in is also present, cfg wins and start is dropped.
  - play_out=1 next cycle (enter RUN), guard restarts, tick counter cleared.
  - First tick_out in the 2nd RUN cycle, then every TICK_DIVn cycles (n = mode_r).
- Tick counter:
  - Width clog2(max DIV); counts 0..DIV-1 and wraps.
  - tick_out=1 on wrap only while in RUN.
- start_in when not IDLE, or before guard elapsed: ignored (no queuing).
- RUN + stop_in:
  - Pended until guard elapsed; pended stop is held internally.
  - Then enter DRAIN; ticks stop immediately.
- Simultaneous start_in and stop_in: stop wins; start ignored in every state.
- DRAIN exit:
  - Ends on the cycle after a falling ws_in edge (frame end), or after DRAIN_MAX cycles, whichever comes first.
  - Then play_out=0, guard restarts, done_out pulses 1 cycle, state IDLE.
- stop_in in IDLE or CFG: ignored; no done_out.
- Guard counter: saturates at MIN_PLAY_CYCLES.
- req_in: ignored except by the optional feature.

Optional Feature:
- Macro: I2S_PLAY_CTRL_UNDERRUN_EN.
- When defined:
  - Adds output underrun_out (1 bit).
  - Set when two req_in pulses occur in RUN with no tick_out between them.
  - Sticky; cleared only on accepted start or reset.
- When undefined: port absent and no logic generated.

Decomposition:
- audioport_pkg additions:
  - typedef enum play_ctrl_state_t {PC_IDLE, PC_CFG, PC_RUN, PC_DRAIN}
  - default TICK_DIV constants
  - I2S_MIN_PLAY_CYCLES=384
- Sub-module i2s_tick_gen: tick divider with mode-selected period, clear and enable inputs.
- FSM and guard logic stay in the top module.

Test Plan:
- Config: cfg_wr_in=1 with cfg_data_in=32'h2 in IDLE -> cfg_out high exactly 1 cycle after; cfg_reg_out=32'h2; play_out stays 0.
- Tick timing:
  - mode 2, start_in pulse -> play_out=1 next cycle; first tick_out 1 cycle later; subsequent ticks every 384 cycles; tick_out never high while play_out=0.
- Early stop:
  - stop_in 10 cycles after start -> stop pended; DRAIN entered at cycle 384 after play rise; ticks cease.
  - play_out falls 1 cycle after next ws_in fall; done_out pulses once.
- Drain timeout: hold ws_in=0 during DRAIN -> play_out falls after exactly 1024 cycles; done_out pulses.
- Simultaneous commands:
  - start_in and stop_in same cycle in IDLE -> no change.
  - cfg_wr_in and start_in same cycle in IDLE -> cfg accepted, play_out stays 0.
- Reset mid-RUN: assert rst_n=0 -> play_out, tick_out, busy_out drop to 0 immediately; start_in right after reset release accepted.
- Underrun (I2S_PLAY_CTRL_UNDERRUN_EN defined): two req_in pulses between ticks -> underrun_out=1, held until next accepted start.
